// File: rtl/tdc_spi_pkg.sv
// Shared constants for the TDC SPI responder: register map, reset values,
// command byte layout and FSM state encoding.
// No logic; imported by tdc_spi_responder and its sub-modules.
package tdc_spi_pkg;

  // Register map (6-bit SPI address space)
  localparam int CFG_REGS        = 10;  // 8-bit config regs at 0x00..0x09
  localparam int MEAS_BASE       = 16;  // 24-bit measurement regs from 0x10
  localparam int ADDR_CONFIG1    = 0;
  localparam int ADDR_INT_STATUS = 2;
  localparam int ADDR_INT_MASK   = 3;

  localparam logic [7:0] INT_MASK_RST = 8'h07;

  // Command byte layout
  localparam int CMD_AUTO_INC_BIT = 7;
  localparam int CMD_RW_BIT       = 6;  // 1 = write
  localparam int CMD_ADDR_MSB     = 5;

  localparam int START_BIT    = 0;  // CONFIG1
  localparam int NEW_MEAS_BIT = 0;  // INT_STATUS / INT_MASK

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  function automatic logic [7:0] cfg_rst_val(input int idx);
    return (idx == ADDR_INT_MASK) ? INT_MASK_RST : 8'h00;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Purpose: STAGES-deep flop synchronizer for one async input, plus edge pulses.
// Latency: lvl follows din after STAGES clk; rise/fall pulse one clk wide in the same cycle lvl changes.
// Backpressure: none (free-running sampler).
// Ports: clk, rst_n; din (async input); lvl (synchronized level); rise/fall (single-cycle edge pulses).
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d[0] = din;
    for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign lvl  = sync_q[STAGES-1];
  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;

endmodule

// File: rtl/tdc_spi_responder.sv
// Purpose: SPI mode-0 slave exposing 8-bit config regs and 24-bit TDC measurement regs.
// Latency: sck/cs_n/mosi seen SYNC_STAGES+1 clk late; miso updates 1 clk after the synced sck edge.
// Backpressure: none; master-paced, sck period must be >= 8 clk.
// Ports: clk/rst_n; sck, cs_n, mosi in, miso/miso_oe out; meas_we/meas_addr/meas_data host
//        write port; meas_done sets NEW_MEAS; start_meas pulse; intb active-low interrupt.
module tdc_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int MEAS_REGS   = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic        meas_we,
  input  logic [3:0]  meas_addr,
  input  logic [23:0] meas_data,
  input  logic        meas_done,
  output logic        start_meas,
  output logic        intb
);
  import tdc_spi_pkg::*;

  logic sck_rise, sck_fall, sck_lvl_unused;
  logic cs_s, cs_fall, cs_rise_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .din(sck),
    .lvl(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall));

  // cs_n idles high, so reset it high to avoid a false falling edge.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(cs_n),
    .lvl(cs_s), .rise(cs_rise_unused), .fall(cs_fall));

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi),
    .lvl(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;   // bits sampled in current cmd byte / register
  logic [6:0]  cmd_sh_q, cmd_sh_d;
  logic [6:0]  wr_sh_q, wr_sh_d;
  logic [23:0] rd_sh_q, rd_sh_d;       // miso is always bit 23
  logic [5:0]  addr_q, addr_d;
  logic        auto_inc_q, auto_inc_d;
  logic        rw_q, rw_d;
  logic        len24_q, len24_d;
  logic        miso_q, miso_d;
  logic        miso_oe_q, miso_oe_d;
  logic        start_meas_q, start_meas_d;
  logic        intb_q, intb_d;
  logic [7:0]  cfg_q [CFG_REGS];
  logic [7:0]  cfg_d [CFG_REGS];
  logic [23:0] meas_q [MEAS_REGS];
  logic [23:0] meas_d [MEAS_REGS];

  logic [7:0]  cmd_byte, wr_byte;
  logic [5:0]  lk_addr;
  logic [23:0] lk_val;
  logic        lk_len24;
  logic        cfg_wr;

  assign cmd_byte = {cmd_sh_q, mosi_s};
  assign wr_byte  = {wr_sh_q, mosi_s};

  // Value/size of the next register to shift out. In CMD this is the address
  // being received; in DATA it is the follow-on register after the current one.
  always_comb begin
    lk_addr = auto_inc_q ? addr_q + 6'd1 : addr_q;
    if (state_q == ST_CMD) lk_addr = cmd_byte[CMD_ADDR_MSB:0];
    lk_val   = '0;
    lk_len24 = 1'b0;
    for (int i = 0; i < CFG_REGS; i++)
      if (lk_addr == 6'(i)) lk_val = {cfg_q[i], 16'h0000};
    for (int i = 0; i < MEAS_REGS; i++)
      if (lk_addr == 6'(MEAS_BASE + i)) begin
        lk_val   = meas_q[i];
        lk_len24 = 1'b1;
      end
  end

  // Frame sequencing
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    cmd_sh_d   = cmd_sh_q;
    wr_sh_d    = wr_sh_q;
    rd_sh_d    = rd_sh_q;
    addr_d     = addr_q;
    auto_inc_d = auto_inc_q;
    rw_d       = rw_q;
    len24_d    = len24_q;
    cfg_wr     = 1'b0;
    case (state_q)
      ST_IDLE: if (cs_fall) begin
        state_d   = ST_CMD;
        bit_cnt_d = '0;
      end
      ST_CMD: if (sck_rise) begin
        cmd_sh_d = cmd_byte[6:0];
        if (bit_cnt_q == 5'd7) begin
          state_d    = ST_DATA;
          auto_inc_d = cmd_byte[CMD_AUTO_INC_BIT];
          rw_d       = cmd_byte[CMD_RW_BIT];
          addr_d     = lk_addr;
          rd_sh_d    = lk_val;
          len24_d    = lk_len24;
          bit_cnt_d  = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      ST_DATA: begin
        // The falling edge right after a register load belongs to the previous
        // bit; shifting there would drop the MSB, hence the bit_cnt guard.
        if (sck_fall && bit_cnt_q != 5'd0) rd_sh_d = {rd_sh_q[22:0], 1'b0};
        if (sck_rise) begin
          wr_sh_d = wr_byte[6:0];
          if (bit_cnt_q == (len24_q ? 5'd23 : 5'd7)) begin
            cfg_wr    = rw_q & ~len24_q;
            addr_d    = lk_addr;
            rd_sh_d   = lk_val;
            len24_d   = lk_len24;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (cs_s) state_d = ST_IDLE;
    miso_oe_d = ~cs_s;
    miso_d    = ~cs_s & (state_d == ST_DATA) & rd_sh_d[23];
  end

  // Register file updates
  always_comb begin
    start_meas_d = 1'b0;
    for (int i = 0; i < CFG_REGS; i++) cfg_d[i] = cfg_q[i];
    if (cfg_wr) begin
      for (int i = 0; i < CFG_REGS; i++)
        if (addr_q == 6'(i)) begin
          if (i == ADDR_CONFIG1) begin
            cfg_d[i]     = wr_byte;
            cfg_d[i][START_BIT] = 1'b0;  // START is a strobe, never stored
            start_meas_d = wr_byte[START_BIT];
          end else if (i == ADDR_INT_STATUS) begin
            if (wr_byte[NEW_MEAS_BIT]) cfg_d[i][NEW_MEAS_BIT] = 1'b0;
          end else begin
            cfg_d[i] = wr_byte;
          end
        end
    end
    // Applied after the clear so a coincident new measurement is never lost.
    if (meas_done) cfg_d[ADDR_INT_STATUS][NEW_MEAS_BIT] = 1'b1;
    intb_d = ~(cfg_q[ADDR_INT_STATUS][NEW_MEAS_BIT] & cfg_q[ADDR_INT_MASK][NEW_MEAS_BIT]);

    for (int i = 0; i < MEAS_REGS; i++) meas_d[i] = meas_q[i];
    if (meas_we && (32'(meas_addr) < MEAS_REGS))
      for (int i = 0; i < MEAS_REGS; i++)
        if (meas_addr == 4'(i)) meas_d[i] = meas_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      cmd_sh_q     <= '0;
      wr_sh_q      <= '0;
      rd_sh_q      <= '0;
      addr_q       <= '0;
      auto_inc_q   <= 1'b0;
      rw_q         <= 1'b0;
      len24_q      <= 1'b0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      start_meas_q <= 1'b0;
      intb_q       <= 1'b1;
      for (int i = 0; i < CFG_REGS; i++) cfg_q[i] <= cfg_rst_val(i);
      for (int i = 0; i < MEAS_REGS; i++) meas_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      cmd_sh_q     <= cmd_sh_d;
      wr_sh_q      <= wr_sh_d;
      rd_sh_q      <= rd_sh_d;
      addr_q       <= addr_d;
      auto_inc_q   <= auto_inc_d;
      rw_q         <= rw_d;
      len24_q      <= len24_d;
      miso_q       <= miso_d;
      miso_oe_q    <= miso_oe_d;
      start_meas_q <= start_meas_d;
      intb_q       <= intb_d;
      for (int i = 0; i < CFG_REGS; i++) cfg_q[i] <= cfg_d[i];
      for (int i = 0; i < MEAS_REGS; i++) meas_q[i] <= meas_d[i];
    end
  end

  assign miso       = miso_q;
  assign miso_oe    = miso_oe_q;
  assign start_meas = start_meas_q;
  assign intb       = intb_q;

endmodule

// File: tb/tb_tdc_spi_responder.sv
// Bench for tdc_spi_responder: drives a mode-0 SPI master (sck = 10 clk),
// compares read bytes against a queue of expected bytes, plus port checks.
`timescale 1ns/1ps
module tb_tdc_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n, sck, cs_n, mosi;
  logic        miso, miso_oe;
  logic        meas_we;
  logic [3:0]  meas_addr;
  logic [23:0] meas_data;
  logic        meas_done;
  logic        start_meas, intb;

  tdc_spi_responder #(.SYNC_STAGES(2), .MEAS_REGS(12)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .meas_we(meas_we), .meas_addr(meas_addr), .meas_data(meas_data),
    .meas_done(meas_done), .start_meas(start_meas), .intb(intb));

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  logic [7:0] sb_q[$];

  always @(negedge clk) if (start_meas === 1'b1) start_cnt++;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic half();
    repeat (5) @(negedge clk);
  endtask

  // 1: meas_done pulse, 2: meas_we idx0 <= 0x777777, 3: reset + checks, 4: check miso_oe
  task automatic do_act(input int act);
    case (act)
      1: meas_done = 1'b1;
      2: begin meas_we = 1'b1; meas_addr = 4'd0; meas_data = 24'h777777; end
      3: rst_n = 1'b0;
      default: ;
    endcase
    @(negedge clk);
    meas_done = 1'b0;
    meas_we   = 1'b0;
    if (act == 3) begin
      chk("rst_mid_miso", 32'(miso), 32'd0);
      chk("rst_mid_oe", 32'(miso_oe), 32'd0);
      chk("rst_mid_intb", 32'(intb), 32'd1);
      chk("rst_mid_start", 32'(start_meas), 32'd0);
    end
    if (act == 4) chk("oe_mid_frame", 32'(miso_oe), 32'd1);
  endtask

  // Shifts nbits of tx (MSB first); miso is captured just before each rising edge.
  task automatic spi_frame(input logic [63:0] tx, input int nbits, input int act_bit,
                           input int act, output logic [63:0] rx);
    rx   = '0;
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[nbits-1-i];
      half();
      rx  = {rx[62:0], miso};
      sck = 1'b1;
      if (i == act_bit) begin
        repeat (2) @(negedge clk);
        do_act(act);
        repeat (2) @(negedge clk);
      end else begin
        half();
      end
      sck = 1'b0;
    end
    half();
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic sb_check(input string name, input logic [63:0] rx, input int nbytes);
    logic [7:0] got, exp;
    for (int k = 0; k < nbytes; k++) begin
      got = rx[8*(nbytes-1-k) +: 8];
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s byte%0d got=0x%0h expected=<none queued>", name, k, got);
      end else begin
        exp = sb_q.pop_front();
        chk($sformatf("%s_b%0d", name, k), 32'(got), 32'(exp));
      end
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    logic [63:0] rx_unused;
    spi_frame({48'h0, 2'b01, a, d}, 16, -1, 0, rx_unused);
  endtask

  task automatic rd(input logic [5:0] a, input logic [7:0] e, input string name);
    logic [63:0] rx;
    sb_q.push_back(e);
    spi_frame({48'h0, 2'b00, a, 8'h00}, 16, -1, 0, rx);
    sb_check(name, rx, 1);
  endtask

  task automatic host_meas(input logic [3:0] idx, input logic [23:0] val);
    meas_we = 1'b1; meas_addr = idx; meas_data = val;
    @(negedge clk);
    meas_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic push3(input logic [23:0] v);
    sb_q.push_back(v[23:16]);
    sb_q.push_back(v[15:8]);
    sb_q.push_back(v[7:0]);
  endtask

  typedef struct {
    logic [5:0] addr;
    logic [7:0] wdat;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[8];

  initial begin
    logic [63:0] rx;
    int s0;

    vecs[0] = '{6'h01, 8'hA5, 8'hA5};
    vecs[1] = '{6'h05, 8'h3C, 8'h3C};
    vecs[2] = '{6'h09, 8'hFF, 8'hFF};  // last config register
    vecs[3] = '{6'h0A, 8'h55, 8'h00};  // first unmapped after config
    vecs[4] = '{6'h3F, 8'h12, 8'h00};
    vecs[5] = '{6'h03, 8'h0F, 8'h0F};  // INT_MASK, bit0 stays set
    vecs[6] = '{6'h08, 8'h81, 8'h81};
    vecs[7] = '{6'h1F, 8'h66, 8'h00};  // beyond the 12 measurement regs

    rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    meas_we = 1'b0; meas_addr = '0; meas_data = '0; meas_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_oe", 32'(miso_oe), 32'd0);
    chk("rst_start", 32'(start_meas), 32'd0);
    chk("rst_intb", 32'(intb), 32'd1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_oe", 32'(miso_oe), 32'd0);

    rd(6'h01, 8'h00, "rst_cfg1");
    rd(6'h03, 8'h07, "rst_mask");
    rd(6'h02, 8'h00, "rst_status");

    for (int v = 0; v < 8; v++) begin
      wr(vecs[v].addr, vecs[v].wdat);
      rd(vecs[v].addr, vecs[v].exp, $sformatf("vec%0d", v));
    end
    chk("no_start_yet", 32'(start_cnt), 32'd0);

    // 24-bit auto-increment read across two measurement registers
    host_meas(4'd0, 24'h123456);
    host_meas(4'd1, 24'hABCDEF);
    host_meas(4'd11, 24'hC0FFEE);
    host_meas(4'd12, 24'hDEAD00);  // out of range, ignored
    push3(24'h123456); push3(24'hABCDEF);
    spi_frame(64'h0090_0000_0000_0000, 56, -1, 0, rx);
    sb_check("autoinc48", rx, 6);

    // Non-increment repeat; idx0 rewritten while the first copy is shifting
    push3(24'h123456); push3(24'h777777);
    spi_frame(64'h0010_0000_0000_0000, 56, 19, 2, rx);
    sb_check("repeat48", rx, 6);

    // Last measurement register, then the unmapped address after it
    push3(24'hC0FFEE); sb_q.push_back(8'h00);
    spi_frame(64'h0000_009B_0000_0000, 40, -1, 0, rx);
    sb_check("meas_edge", rx, 4);

    // SPI writes to measurement registers are ignored
    spi_frame(64'h0000_0000_51FF_FFFF, 32, -1, 0, rx);
    push3(24'hABCDEF);
    spi_frame(64'h0000_0000_1100_0000, 32, -1, 0, rx);
    sb_check("meas_ro", rx, 3);

    // START strobe
    s0 = start_cnt;
    wr(6'h00, 8'h03);
    chk("start_pulses", 32'(start_cnt - s0), 32'd1);
    rd(6'h00, 8'h02, "cfg1_rb");

    // Address wrap 0x3F -> 0x00 with auto-increment
    sb_q.push_back(8'h00); sb_q.push_back(8'h02);
    spi_frame(64'h0000_0000_00BF_0000, 24, 3, 4, rx);
    sb_check("wrap", rx, 2);

    // Abort after 5 data bits of a write to 0x01
    spi_frame(64'h0000_0000_0000_082B, 13, -1, 0, rx);
    chk("abort_oe", 32'(miso_oe), 32'd0);
    rd(6'h01, 8'hA5, "abort_keep");

    // Interrupt
    chk("int_idle", 32'(intb), 32'd1);
    meas_done = 1'b1;
    @(negedge clk);
    meas_done = 1'b0;
    @(negedge clk);
    chk("int_low", 32'(intb), 32'd0);
    rd(6'h02, 8'h01, "int_status");
    wr(6'h02, 8'h01);
    chk("int_cleared", 32'(intb), 32'd1);
    rd(6'h02, 8'h00, "int_status_clr");
    meas_done = 1'b1;
    @(negedge clk);
    meas_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("int_low2", 32'(intb), 32'd0);
    spi_frame(64'h0000_0000_0000_4201, 16, 15, 1, rx);  // clear coincides with meas_done
    chk("int_set_wins", 32'(intb), 32'd0);
    rd(6'h02, 8'h01, "int_status_set");

    // Reset during a read whose first data bit is 1
    spi_frame(64'h0000_0000_0000_1100, 16, 8, 3, rx);
    chk("rst_first_bit", 32'(rx[7]), 32'd1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_intb", 32'(intb), 32'd1);
    rd(6'h01, 8'h00, "post_rst_cfg1");
    rd(6'h03, 8'h07, "post_rst_mask");
    rd(6'h02, 8'h00, "post_rst_status");
    push3(24'h000000);
    spi_frame(64'h0000_0000_1000_0000, 32, -1, 0, rx);
    sb_check("post_rst_meas", rx, 3);

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdc_spi_responder.md
TDC_SPI_RESPONDER -- requirements
Module: tdc_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for sck/cs_n/mosi.
REQ-002 SHALL have parameter MEAS_REGS, default 12, meaning number of 24-bit read-only measurement registers.
REQ-003 SHALL have ports as listed:
  clk  in  1  system clock, 50 MHz; only clock.
  rst_n  in  1  asynchronous active-low reset.
  sck  in  1  SPI clock from master (mode 0).
  cs_n  in  1  SPI chip select, active low.
  mosi  in  1  master-out data.
  miso  out  1  slave-out data.
  miso_oe  out  1  high while cs_n low after synchronization.
  meas_we  in  1  host write strobe for measurement register.
  meas_addr  in  4  measurement index 0..MEAS_REGS-1.
  meas_data  in  24  measurement value.
  meas_done  in  1  one-cycle pulse; sets NEW_MEAS interrupt.
  start_meas  out  1  one-cycle pulse on START write.
  intb  out  1  interrupt, active low.

Function
REQ-004 SHALL sample mosi on synchronized sck rising edge and update miso on falling edge, MSB first.
REQ-005 SHALL require sck period >= 8 clk cycles; faster sck is unsupported.
REQ-006 SHALL use FSM IDLE -> CMD (cs_n falls) -> DATA (8th cmd bit) -> IDLE (cs_n rises, from any state).
REQ-007 SHALL decode command byte: bit7 AUTO_INC, bit6 RW (1=write), bits5:0 address.
REQ-008 SHALL map 8-bit config regs at 0x00..0x09 and 24-bit measurement regs at 0x10..0x10+MEAS_REGS-1.
REQ-009 SHALL return 0x00 per byte for reads of unmapped addresses; writes to unmapped or measurement addresses ignored.
REQ-010 SHALL transfer 24-bit regs as 3 bytes MSB first; 8-bit regs as 1 byte.
REQ-011 SHALL snapshot the full register value into the read shifter at register start; meas_we during shifting does not alter bytes in flight.
REQ-012 SHALL load the first read bit onto miso within 2 clk cycles of the 8th command rising edge, before the first data falling edge.
REQ-013 SHALL, after each complete register, increment address by 1 if AUTO_INC, else repeat same address; 6-bit address wraps 0x3F -> 0x00.
REQ-014 SHALL commit a config write only on the 8th data bit of that byte; partial bytes at cs_n rise are discarded.
REQ-015 SHALL treat CONFIG1 (0x00) bit0 as START: writing 1 pulses start_meas for one clk; bit0 reads back 0.
REQ-016 SHALL set INT_STATUS (0x02) bit0 on meas_done; writing 1 to bit0 clears it; simultaneous set and clear: set wins.
REQ-017 SHALL drive intb = ~(INT_STATUS[0] & INT_MASK(0x03)[0]), registered.
REQ-018 SHALL write measurement regs via meas_we/meas_addr/meas_data in one clk; meas_addr >= MEAS_REGS ignored.
REQ-019 SHALL drive miso 0 when miso_oe is low.

Reset
REQ-020 SHALL on rst_n low asynchronously force FSM IDLE, miso 0, miso_oe 0, start_meas 0, intb 1.
REQ-021 SHALL reset config regs to 0x00 except INT_MASK 0x07; measurement regs to 0.
REQ-022 SHALL abort any transfer when reset asserts mid-frame; no register is modified by that frame.

Structure
REQ-023 SHALL place register address constants, reset values, FSM state encoding and command bit positions in shared package tdc_spi_pkg.
REQ-024 SHALL instantiate one sub-module spi_sync_edge (SYNC_STAGES flop synchronizer plus rise/fall pulse) for sck, cs_n and mosi.

Verification
REQ-025 Config write/read: write cmd 0x41 data 0xA5, then read cmd 0x01 -> miso returns 0xA5.
REQ-026 24-bit auto-inc read: meas 0x123456 @idx0, 0xABCDEF @idx1, cmd 0x90, 48 sck -> 0x12,0x34,0x56,0xAB,0xCD,0xEF.
REQ-027 Non-inc repeat: cmd 0x10, 48 sck -> 0x123456 twice; meas_we to idx0 mid-read -> first register bytes unchanged.
REQ-028 Interrupt: meas_done pulse -> intb low within 2 clk; write 0x01 to 0x02 -> intb high; meas_done coincident with clear -> intb stays low.
REQ-029 Abort: cs_n rises after 5 data bits of write to 0x01 -> reg 0x01 unchanged, FSM IDLE; rst_n low mid-read -> miso 0, intb 1.
REQ-030 START: write 0x03 to 0x00 -> exactly one start_meas pulse; readback of 0x00 = 0x02.
